// File: rtl/onehot_scan_decoder_pkg.sv
// Shared constants and helpers for the one-hot scan decoder and its prescaler.
package onehot_scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Counter width for a divide-by-div prescaler; never narrower than one bit.
    function automatic int prescale_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/onehot_scan_decoder_tick_prescaler.sv
// Enable-gated modulo-DIV counter that emits a tick on the enabled cycle at terminal count.
module tick_prescaler
    import onehot_scan_decoder_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = prescale_width(DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == TERM);

    // Count is held (not cleared) while en is low so a paused scan resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clr || w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tick = en & ~clr & w_term;

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with handshaked direct load and prescaled up/down scan.
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    dir,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    step
);

    localparam int OUT_W = 1 << SEL_W;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return ACTIVE_LOW ? ~v : v;
    endfunction

    logic [SEL_W-1:0] r_idx;
    logic [OUT_W-1:0] r_out;
    logic             r_step;
    logic             r_mode;

    logic             w_mode_chg;
    logic             w_ps_clr;
    logic             w_tick;
    logic             w_load;
    logic [SEL_W-1:0] w_idx_nxt;

    assign w_mode_chg = en & (mode != r_mode);
    // Direct mode parks the prescaler at 0; any mode switch restarts the scan period.
    assign w_ps_clr   = (mode == MODE_DIRECT) | w_mode_chg;
    assign w_load     = en & (mode == MODE_DIRECT) & sel_valid;

    tick_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (w_ps_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_load) begin
            w_idx_nxt = sel;
        end else if (w_tick) begin
            w_idx_nxt = (dir == DIR_DOWN) ? r_idx - 1'b1 : r_idx + 1'b1;
        end
    end

    // r_mode tracks mode during reset so leaving reset in scan mode is not a mode switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_out  <= decode('0);
            r_step <= 1'b0;
            r_mode <= mode;
        end else begin
            r_idx  <= w_idx_nxt;
            r_out  <= decode(w_idx_nxt);
            r_step <= w_tick;
            if (en) begin
                r_mode <= mode;
            end
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign step = r_step;

endmodule
